// File: rtl/bus_err_drain_ctrl.sv
// Shares one error-record consumer between NumUnits bus error units.
// Round-robin grants a pending unit, pops one FIFO entry, holds the record until handshake.
module bus_err_drain_ctrl #(
    parameter int unsigned NumUnits      = 4,
    parameter int unsigned AddrWidth     = 48,
    parameter int unsigned MetaDataWidth = 1,
    parameter int unsigned ErrBits       = 3,
    parameter int unsigned CntWidth      = 8,
    localparam int unsigned IdxWidth     = (NumUnits > 1) ? $clog2(NumUnits) : 1
) (
    input  logic                                        clk_i,
    input  logic                                        rst_ni,
    input  logic [NumUnits-1:0]                         unit_irq_i,
    input  logic [NumUnits-1:0][ErrBits-1:0]            unit_code_i,
    input  logic [NumUnits-1:0][AddrWidth-1:0]          unit_addr_i,
    input  logic [NumUnits-1:0][MetaDataWidth-1:0]      unit_meta_i,
    input  logic [NumUnits-1:0]                         unit_overflow_i,
    output logic [NumUnits-1:0]                         unit_pop_o,
    output logic                                        rec_valid_o,
    input  logic                                        rec_ready_i,
    output logic [IdxWidth-1:0]                         rec_unit_o,
    output logic [ErrBits-1:0]                          rec_code_o,
    output logic [AddrWidth-1:0]                        rec_addr_o,
    output logic [MetaDataWidth-1:0]                    rec_meta_o,
    output logic                                        rec_overflow_o,
    output logic [CntWidth-1:0]                         ovf_cnt_o,
    input  logic                                        ovf_clr_i,
    output logic                                        busy_o
);

    localparam logic [0:0] StIdle = 1'b0;
    localparam logic [0:0] StHold = 1'b1;

    localparam int unsigned SumWidth = CntWidth + IdxWidth + 1;
    localparam logic [SumWidth-1:0] CntMax = {{(IdxWidth + 1){1'b0}}, {CntWidth{1'b1}}};

    logic [0:0]               state_q, state_d;
    logic [IdxWidth-1:0]      rr_ptr_q, rr_ptr_d;
    logic [IdxWidth-1:0]      rec_unit_q, rec_unit_d;
    logic [ErrBits-1:0]       rec_code_q, rec_code_d;
    logic [AddrWidth-1:0]     rec_addr_q, rec_addr_d;
    logic [MetaDataWidth-1:0] rec_meta_q, rec_meta_d;
    logic                     rec_overflow_q, rec_overflow_d;
    logic [CntWidth-1:0]      ovf_cnt_q, ovf_cnt_d;
    logic [NumUnits-1:0]      ovf_prev_q, ovf_prev_d;

    logic                     gnt_found;
    logic [IdxWidth-1:0]      gnt_idx;
    logic [IdxWidth:0]        cand;
    logic [NumUnits-1:0]      ovf_rise;
    logic [IdxWidth:0]        rise_cnt;
    logic [SumWidth-1:0]      cnt_sum;

    // Scan upward from rr_ptr with wrap; the extra bit keeps rr_ptr+i from overflowing.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int unsigned i = 0; i < NumUnits; i++) begin
            cand = {1'b0, rr_ptr_q} + (IdxWidth + 1)'(i);
            if (cand >= (IdxWidth + 1)'(NumUnits)) begin
                cand = cand - (IdxWidth + 1)'(NumUnits);
            end
            if (!gnt_found && unit_irq_i[cand[IdxWidth-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand[IdxWidth-1:0];
            end
        end
    end

    always_comb begin
        unit_pop_o = '0;
        if (state_q == StIdle && gnt_found) begin
            unit_pop_o[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        state_d        = state_q;
        rr_ptr_d       = rr_ptr_q;
        rec_unit_d     = rec_unit_q;
        rec_code_d     = rec_code_q;
        rec_addr_d     = rec_addr_q;
        rec_meta_d     = rec_meta_q;
        rec_overflow_d = rec_overflow_q;
        case (state_q)
            StIdle: begin
                if (gnt_found) begin
                    state_d        = StHold;
                    rec_unit_d     = gnt_idx;
                    rec_code_d     = unit_code_i[gnt_idx];
                    rec_addr_d     = unit_addr_i[gnt_idx];
                    rec_meta_d     = unit_meta_i[gnt_idx];
                    rec_overflow_d = unit_overflow_i[gnt_idx];
                end
            end
            StHold: begin
                if (rec_ready_i) begin
                    state_d  = StIdle;
                    rr_ptr_d = (rec_unit_q == IdxWidth'(NumUnits - 1)) ? '0
                                                                       : rec_unit_q + IdxWidth'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Overflow events: rising edges of every unit summed, saturating, clear wins.
    always_comb begin
        ovf_rise   = unit_overflow_i & ~ovf_prev_q;
        ovf_prev_d = unit_overflow_i;
        rise_cnt   = '0;
        for (int unsigned i = 0; i < NumUnits; i++) begin
            rise_cnt = rise_cnt + (IdxWidth + 1)'(ovf_rise[i]);
        end
        cnt_sum = SumWidth'(ovf_cnt_q) + SumWidth'(rise_cnt);
        if (ovf_clr_i) begin
            ovf_cnt_d = '0;
        end else if (cnt_sum > CntMax) begin
            ovf_cnt_d = '1;
        end else begin
            ovf_cnt_d = cnt_sum[CntWidth-1:0];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= StIdle;
            rr_ptr_q       <= '0;
            rec_unit_q     <= '0;
            rec_code_q     <= '0;
            rec_addr_q     <= '0;
            rec_meta_q     <= '0;
            rec_overflow_q <= 1'b0;
            ovf_cnt_q      <= '0;
            ovf_prev_q     <= '0;
        end else begin
            state_q        <= state_d;
            rr_ptr_q       <= rr_ptr_d;
            rec_unit_q     <= rec_unit_d;
            rec_code_q     <= rec_code_d;
            rec_addr_q     <= rec_addr_d;
            rec_meta_q     <= rec_meta_d;
            rec_overflow_q <= rec_overflow_d;
            ovf_cnt_q      <= ovf_cnt_d;
            ovf_prev_q     <= ovf_prev_d;
        end
    end

    assign rec_valid_o    = (state_q == StHold);
    assign busy_o         = (state_q == StHold);
    assign rec_unit_o     = rec_unit_q;
    assign rec_code_o     = rec_code_q;
    assign rec_addr_o     = rec_addr_q;
    assign rec_meta_o     = rec_meta_q;
    assign rec_overflow_o = rec_overflow_q;
    assign ovf_cnt_o      = ovf_cnt_q;

    // A unit must never be popped while empty or while a record is outstanding.
    pop_onehot0_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot0(unit_pop_o));
    pop_only_pending_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (unit_pop_o & ~unit_irq_i) == '0);
    no_pop_in_hold_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
        rec_valid_o |-> unit_pop_o == '0);

endmodule

// File: tb/tb_bus_err_drain_ctrl.sv
// Bench for bus_err_drain_ctrl: vector table, directed corner sequences and a randomized run
// against a behavioural model; a second instance covers NumUnits=3 and a 2-bit counter.
module tb_bus_err_drain_ctrl;

    logic              clk;
    logic              rst_n;

    logic [3:0]        irq;
    logic [3:0][2:0]   code;
    logic [3:0][47:0]  addr;
    logic [3:0][0:0]   meta;
    logic [3:0]        ovf;
    logic [3:0]        pop;
    logic              valid;
    logic              ready;
    logic [1:0]        runit;
    logic [2:0]        rcode;
    logic [47:0]       raddr;
    logic [0:0]        rmeta;
    logic              rovf;
    logic [7:0]        cnt;
    logic              clr;
    logic              busy;

    logic [2:0]        irq3;
    logic [2:0][2:0]   code3;
    logic [2:0][15:0]  addr3;
    logic [2:0][0:0]   meta3;
    logic [2:0]        ovf3;
    logic [2:0]        pop3;
    logic              valid3;
    logic              ready3;
    logic [1:0]        runit3;
    logic [2:0]        rcode3;
    logic [15:0]       raddr3;
    logic [0:0]        rmeta3;
    logic              rovf3;
    logic [1:0]        cnt3;
    logic              clr3;
    logic              busy3;

    int n_checks = 0;
    int n_fail   = 0;

    bus_err_drain_ctrl dut (
        .clk_i(clk), .rst_ni(rst_n),
        .unit_irq_i(irq), .unit_code_i(code), .unit_addr_i(addr), .unit_meta_i(meta),
        .unit_overflow_i(ovf), .unit_pop_o(pop),
        .rec_valid_o(valid), .rec_ready_i(ready), .rec_unit_o(runit),
        .rec_code_o(rcode), .rec_addr_o(raddr), .rec_meta_o(rmeta),
        .rec_overflow_o(rovf), .ovf_cnt_o(cnt), .ovf_clr_i(clr), .busy_o(busy)
    );

    bus_err_drain_ctrl #(.NumUnits(3), .AddrWidth(16), .CntWidth(2)) dut3 (
        .clk_i(clk), .rst_ni(rst_n),
        .unit_irq_i(irq3), .unit_code_i(code3), .unit_addr_i(addr3), .unit_meta_i(meta3),
        .unit_overflow_i(ovf3), .unit_pop_o(pop3),
        .rec_valid_o(valid3), .rec_ready_i(ready3), .rec_unit_o(runit3),
        .rec_code_o(rcode3), .rec_addr_o(raddr3), .rec_meta_o(rmeta3),
        .rec_overflow_o(rovf3), .ovf_cnt_o(cnt3), .ovf_clr_i(clr3), .busy_o(busy3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        irq = '0; code = '0; addr = '0; meta = '0; ovf = '0; ready = 1'b0; clr = 1'b0;
        irq3 = '0; code3 = '0; addr3 = '0; meta3 = '0; ovf3 = '0; ready3 = 1'b0; clr3 = 1'b0;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_pop"},   64'(pop),   64'h0);
        check({tag, "_valid"}, 64'(valid), 64'h0);
        check({tag, "_busy"},  64'(busy),  64'h0);
        check({tag, "_unit"},  64'(runit), 64'h0);
        check({tag, "_code"},  64'(rcode), 64'h0);
        check({tag, "_addr"},  64'(raddr), 64'h0);
        check({tag, "_meta"},  64'(rmeta), 64'h0);
        check({tag, "_rovf"},  64'(rovf),  64'h0);
        check({tag, "_cnt"},   64'(cnt),   64'h0);
    endtask

    typedef struct {
        logic [3:0] irq;
        logic       ready;
        logic [3:0] ovf;
        logic       clr;
        logic [3:0] pop;
        logic       valid;
        logic [1:0] unit;
        logic [7:0] cnt;
    } vec_t;

    vec_t tbl[13];

    // Behavioural model state for the randomized run
    bit         m_hold;
    int         m_rr;
    int         m_unit;
    logic [2:0] m_code;
    logic [47:0] m_addr;
    logic       m_meta;
    logic       m_rovf;
    int         m_cnt;
    logic [3:0] m_prev;

    function automatic int find_grant(input logic [3:0] req, input int start);
        for (int k = 0; k < 4; k++) begin
            if (req[(start + k) % 4]) return (start + k) % 4;
        end
        return -1;
    endfunction

    initial begin
        int pops;
        int g;
        logic [3:0] exp_pop;

        // irq, ready, ovf, clr | pop, valid, unit, cnt
        tbl[0]  = '{4'hF, 1'b1, 4'h0, 1'b0, 4'b0001, 1'b0, 2'd0, 8'd0};
        tbl[1]  = '{4'hF, 1'b1, 4'h9, 1'b0, 4'b0000, 1'b1, 2'd0, 8'd0};
        tbl[2]  = '{4'hF, 1'b1, 4'h9, 1'b0, 4'b0010, 1'b0, 2'd0, 8'd2};
        tbl[3]  = '{4'hF, 1'b1, 4'h0, 1'b0, 4'b0000, 1'b1, 2'd1, 8'd2};
        tbl[4]  = '{4'hF, 1'b1, 4'h0, 1'b0, 4'b0100, 1'b0, 2'd1, 8'd2};
        tbl[5]  = '{4'hF, 1'b0, 4'h2, 1'b0, 4'b0000, 1'b1, 2'd2, 8'd2};
        tbl[6]  = '{4'hF, 1'b1, 4'h6, 1'b1, 4'b0000, 1'b1, 2'd2, 8'd3};
        tbl[7]  = '{4'h5, 1'b1, 4'h0, 1'b0, 4'b0001, 1'b0, 2'd2, 8'd0};
        tbl[8]  = '{4'h0, 1'b1, 4'h0, 1'b0, 4'b0000, 1'b1, 2'd0, 8'd0};
        tbl[9]  = '{4'h0, 1'b1, 4'h0, 1'b0, 4'b0000, 1'b0, 2'd0, 8'd0};
        tbl[10] = '{4'hC, 1'b1, 4'h0, 1'b0, 4'b0100, 1'b0, 2'd0, 8'd0};
        tbl[11] = '{4'hC, 1'b1, 4'h0, 1'b0, 4'b0000, 1'b1, 2'd2, 8'd0};
        tbl[12] = '{4'hC, 1'b1, 4'h0, 1'b0, 4'b1000, 1'b0, 2'd2, 8'd0};

        clear_inputs();
        do_reset();
        check_reset_values("reset");
        check("reset_pop3",   64'(pop3),   64'h0);
        check("reset_valid3", 64'(valid3), 64'h0);
        check("reset_cnt3",   64'(cnt3),   64'h0);

        // Vector table: round robin, 2-cycle spacing, overflow sums, clear priority, wrap
        for (int i = 0; i < 13; i++) begin
            irq = tbl[i].irq; ready = tbl[i].ready; ovf = tbl[i].ovf; clr = tbl[i].clr;
            @(negedge clk);
            check($sformatf("tbl%0d_pop", i),   64'(pop),   64'(tbl[i].pop));
            check($sformatf("tbl%0d_valid", i), 64'(valid), 64'(tbl[i].valid));
            check($sformatf("tbl%0d_busy", i),  64'(busy),  64'(tbl[i].valid));
            check($sformatf("tbl%0d_unit", i),  64'(runit), 64'(tbl[i].unit));
            check($sformatf("tbl%0d_cnt", i),   64'(cnt),   64'(tbl[i].cnt));
            tick();
        end

        // Single error on unit 2
        do_reset();
        irq = 4'b0100; code[2] = 3'b010; addr[2] = 48'h1000; meta[2] = 1'b1; ready = 1'b1;
        @(negedge clk);
        check("single_pop", 64'(pop), 64'h4);
        check("single_valid_early", 64'(valid), 64'h0);
        tick();
        irq = '0;
        @(negedge clk);
        check("single_valid", 64'(valid), 64'h1);
        check("single_unit",  64'(runit), 64'h2);
        check("single_code",  64'(rcode), 64'h2);
        check("single_addr",  64'(raddr), 64'h1000);
        check("single_meta",  64'(rmeta), 64'h1);
        check("single_pop_hold", 64'(pop), 64'h0);
        tick();
        @(negedge clk);
        check("single_valid_drop", 64'(valid), 64'h0);

        // Backpressure on unit 1: record held, single pop
        tick();
        pops = 0;
        irq = 4'b0010; code[1] = 3'd5; addr[1] = 48'hABCD_0000_1234; meta[1] = 1'b0;
        ovf = 4'b0010; ready = 1'b0;
        @(negedge clk);
        pops += $countones(pop);
        check("bp_first_pop", 64'(pop), 64'h2);
        tick();
        code[1] = 3'd6; addr[1] = 48'h5555; meta[1] = 1'b1; ovf = 4'b0000;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            pops += $countones(pop);
            check($sformatf("bp%0d_valid", c), 64'(valid), 64'h1);
            check($sformatf("bp%0d_busy", c),  64'(busy),  64'h1);
            check($sformatf("bp%0d_unit", c),  64'(runit), 64'h1);
            check($sformatf("bp%0d_code", c),  64'(rcode), 64'h5);
            check($sformatf("bp%0d_addr", c),  64'(raddr), 64'hABCD_0000_1234);
            check($sformatf("bp%0d_rovf", c),  64'(rovf),  64'h1);
            tick();
        end
        ready = 1'b1; irq = '0;
        @(negedge clk);
        pops += $countones(pop);
        check("bp_handshake_valid", 64'(valid), 64'h1);
        tick();
        @(negedge clk);
        pops += $countones(pop);
        check("bp_after_valid", 64'(valid), 64'h0);
        check("bp_after_busy",  64'(busy),  64'h0);
        check("bp_total_pops",  64'(pops),  64'h1);

        // Reset while holding: pointer was at 2, must restart at 0
        tick();
        irq = 4'hF; ready = 1'b0;
        @(negedge clk);
        check("rst_hold_pop", 64'(pop), 64'h4);
        tick();
        @(negedge clk);
        check("rst_hold_valid", 64'(valid), 64'h1);
        #2;
        rst_n = 1'b0;
        irq = '0;
        #1;
        check_reset_values("async_reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1; irq = 4'hF; ready = 1'b1;
        @(negedge clk);
        check("rst_rr_zero_pop", 64'(pop), 64'h1);
        tick();
        irq = '0;

        // NumUnits=3: grant 2 wraps to 0, then grant 0 moves pointer to 1
        irq3 = 3'b100; ready3 = 1'b1;
        @(negedge clk);
        check("n3_pop_u2", 64'(pop3), 64'h4);
        tick();
        irq3 = '0;
        @(negedge clk);
        check("n3_valid", 64'(valid3), 64'h1);
        check("n3_unit2", 64'(runit3), 64'h2);
        tick();
        irq3 = 3'b101;
        @(negedge clk);
        check("n3_wrap_pop", 64'(pop3), 64'h1);
        tick();
        irq3 = '0;
        @(negedge clk);
        check("n3_unit0", 64'(runit3), 64'h0);
        tick();
        irq3 = 3'b101;
        @(negedge clk);
        check("n3_next_pop", 64'(pop3), 64'h4);
        tick();
        irq3 = '0;
        tick();

        // 2-bit counter saturation, then clear beating a coincident edge
        for (int e = 0; e < 5; e++) begin
            ovf3 = 3'b001;
            tick();
            ovf3 = 3'b000;
            @(negedge clk);
            check($sformatf("sat_edge%0d", e), 64'(cnt3), 64'((e + 1 > 3) ? 3 : e + 1));
            tick();
        end
        ovf3 = 3'b011; clr3 = 1'b1;
        tick();
        clr3 = 1'b0;
        @(negedge clk);
        check("clr_with_edge", 64'(cnt3), 64'h0);
        tick();
        ovf3 = '0;

        // Randomized run against the behavioural model
        do_reset();
        m_hold = 0; m_rr = 0; m_unit = 0; m_code = '0; m_addr = '0; m_meta = 1'b0;
        m_rovf = 1'b0; m_cnt = 0; m_prev = '0;
        for (int c = 0; c < 600; c++) begin
            irq   = 4'($urandom_range(0, 15));
            ready = ($urandom_range(0, 9) < 7);
            clr   = ($urandom_range(0, 24) == 0);
            for (int u = 0; u < 4; u++) begin
                code[u] = 3'($urandom);
                addr[u] = {16'($urandom), 32'($urandom)};
                meta[u] = 1'($urandom);
                if ($urandom_range(0, 5) == 0) ovf[u] = ~ovf[u];
            end
            @(negedge clk);
            g = find_grant(irq, m_rr);
            exp_pop = (!m_hold && g >= 0) ? 4'(1 << g) : 4'h0;
            check("rnd_pop",   64'(pop),   64'(exp_pop));
            check("rnd_valid", 64'(valid), 64'(m_hold));
            check("rnd_busy",  64'(busy),  64'(m_hold));
            check("rnd_unit",  64'(runit), 64'(m_unit));
            check("rnd_code",  64'(rcode), 64'(m_code));
            check("rnd_addr",  64'(raddr), 64'(m_addr));
            check("rnd_meta",  64'(rmeta), 64'(m_meta));
            check("rnd_rovf",  64'(rovf),  64'(m_rovf));
            check("rnd_cnt",   64'(cnt),   64'(m_cnt));
            if (!m_hold) begin
                if (g >= 0) begin
                    m_hold = 1; m_unit = g; m_code = code[g]; m_addr = addr[g];
                    m_meta = meta[g][0]; m_rovf = ovf[g];
                end
            end else if (ready) begin
                m_hold = 0;
                m_rr = (m_unit + 1) % 4;
            end
            if (clr) m_cnt = 0;
            else begin
                m_cnt = m_cnt + $countones(ovf & ~m_prev);
                if (m_cnt > 255) m_cnt = 255;
            end
            m_prev = ovf;
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
